// File: rtl/traffic_conflict_monitor_pkg.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor_pkg
// Shared definitions for the traffic conflict monitor:
//   - lamp bit positions inside a 3-bit lamp vector
//   - lamp FSM state encoding
//   - fault codes (1 = highest priority, 5 = lowest)
//   - seven-segment digit patterns (bit0 = a ... bit6 = g, active-high)
//   - small helpers for lamp vector classification and FSM move legality
// -----------------------------------------------------------------------------
package traffic_conflict_monitor_pkg;

    localparam logic [6:0] MAX_COUNT_DEFAULT = 7'd99;

    localparam int unsigned LAMP_RED    = 2;
    localparam int unsigned LAMP_YELLOW = 1;
    localparam int unsigned LAMP_GREEN  = 0;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_RED     = 2'd3
    } lamp_state_t;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_LAMP     = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEGMENT  = 3'd3,
        FC_STEP     = 3'd4,
        FC_SEQUENCE = 3'd5
    } fault_code_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    // Exactly one lamp lit.
    function automatic logic lamp_onehot(input logic [2:0] lamps);
        return (lamps == 3'b001) || (lamps == 3'b010) || (lamps == 3'b100);
    endfunction

    // Lamp vector to FSM state; anything not one-hot is UNKNOWN.
    function automatic lamp_state_t lamp_to_state(input logic [2:0] lamps);
        lamp_state_t st;
        if (!lamp_onehot(lamps)) begin
            st = ST_UNKNOWN;
        end else if (lamps[LAMP_RED]) begin
            st = ST_RED;
        end else if (lamps[LAMP_YELLOW]) begin
            st = ST_YELLOW;
        end else begin
            st = ST_GREEN;
        end
        return st;
    endfunction

    // GREEN->YELLOW->RED->GREEN, holding, and leaving UNKNOWN are legal.
    function automatic logic legal_move(input lamp_state_t cur_s, input lamp_state_t nxt_s);
        logic ok;
        if ((cur_s == ST_UNKNOWN) || (cur_s == nxt_s)) begin
            ok = 1'b1;
        end else begin
            case (cur_s)
                ST_GREEN:  ok = (nxt_s == ST_YELLOW);
                ST_YELLOW: ok = (nxt_s == ST_RED);
                ST_RED:    ok = (nxt_s == ST_GREEN);
                default:   ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor_if
// Bundle between the traffic light controller side (master: drives lamps,
// displays and clear) and the monitor (slave: returns decoded counts and the
// latched fault).
//   row/column_traffic_lights [2:0]  lamps, bit2 red, bit1 yellow, bit0 green
//   row/column_display       [13:0]  [13:7] tens, [6:0] ones, gfedcba
//   clear                            synchronous fault clear
//   row/column_count          [6:0]  decoded countdown (0 when invalid/blank)
//   row/column_count_valid           display decoded to a legal number
//   fault, fault_code         [2:0]  latched first fault
// -----------------------------------------------------------------------------
interface traffic_conflict_monitor_if;
    logic [2:0]  row_traffic_lights;
    logic [2:0]  column_traffic_lights;
    logic [13:0] row_display;
    logic [13:0] column_display;
    logic        clear;
    logic [6:0]  row_count;
    logic [6:0]  column_count;
    logic        row_count_valid;
    logic        column_count_valid;
    logic        fault;
    logic [2:0]  fault_code;

    modport master (
        output row_traffic_lights, column_traffic_lights, row_display, column_display, clear,
        input  row_count, column_count, row_count_valid, column_count_valid, fault, fault_code
    );

    modport slave (
        input  row_traffic_lights, column_traffic_lights, row_display, column_display, clear,
        output row_count, column_count, row_count_valid, column_count_valid, fault, fault_code
    );
endinterface

// File: rtl/traffic_conflict_monitor_segment_to_bcd.sv
// -----------------------------------------------------------------------------
// segment_to_bcd
// Combinational decode of one seven-segment pattern.
//   i_seg   [6:0]  pattern, bit0 = a ... bit6 = g
//   o_digit [3:0]  decoded digit (0 when not legal)
//   o_legal        pattern is one of the ten digits
//   o_blank        pattern is all segments off
// -----------------------------------------------------------------------------
module segment_to_bcd
    import traffic_conflict_monitor_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_legal,
    output logic       o_blank
);

    // Pattern lookup; any unlisted pattern is neither a digit nor blank.
    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        o_blank = 1'b0;
        case (i_seg)
            SEG_0: o_digit = 4'd0;
            SEG_1: o_digit = 4'd1;
            SEG_2: o_digit = 4'd2;
            SEG_3: o_digit = 4'd3;
            SEG_4: o_digit = 4'd4;
            SEG_5: o_digit = 4'd5;
            SEG_6: o_digit = 4'd6;
            SEG_7: o_digit = 4'd7;
            SEG_8: o_digit = 4'd8;
            SEG_9: o_digit = 4'd9;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
// Independent checker on the controller's lamp and display outputs.
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    traffic_conflict_monitor_if.slave (lamps, displays, clear in;
//          decoded counts, valid flags, fault, fault_code out)
// Inputs are captured into a sample stage; checks compare the sample against
// the previous sample, which is held in decoded form (r_count/r_valid) and as
// the lamp FSM state. Outputs are registered one edge after the sample, giving
// two cycles from input change to output.
// -----------------------------------------------------------------------------
module traffic_conflict_monitor
    import traffic_conflict_monitor_pkg::*;
#(
    parameter logic [6:0] MAX_COUNT = MAX_COUNT_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    traffic_conflict_monitor_if.slave     bus
);

    localparam int DIR_ROW = 0;
    localparam int DIR_COL = 1;

    // sample stage
    logic [1:0][2:0]  r_s_lamp;
    logic [1:0][13:0] r_s_disp;
    logic             r_s_clear;
    logic [1:0]       r_warm;

    // lamp FSMs
    lamp_state_t r_state      [2];
    lamp_state_t w_next_state [2];
    logic [1:0]  w_onehot;
    logic [1:0]  w_changed;
    logic [1:0]  w_bad_move;

    // display decode
    logic [1:0][3:0] w_tens_digit;
    logic [1:0][3:0] w_ones_digit;
    logic [1:0]      w_tens_legal;
    logic [1:0]      w_ones_legal;
    logic [1:0]      w_tens_blank;
    logic [1:0]      w_ones_blank;
    logic [1:0][6:0] w_two_digit;
    logic [1:0][6:0] w_cur_count;
    logic [1:0]      w_cur_valid;
    logic [1:0]      w_seg_bad;
    logic [1:0]      w_bad_step;

    // fault selection and latch
    logic        w_lamp_chk;
    fault_code_t w_code;
    logic        w_fault_next;
    logic [2:0]  w_code_next;

    // output registers (also the previous decoded sample)
    logic [1:0][6:0] r_count;
    logic [1:0]      r_valid;
    logic            r_fault;
    logic [2:0]      r_fault_code;

    for (genvar g = 0; g < 2; g++) begin : g_dec
        segment_to_bcd u_tens (
            .i_seg   (r_s_disp[g][13:7]),
            .o_digit (w_tens_digit[g]),
            .o_legal (w_tens_legal[g]),
            .o_blank (w_tens_blank[g])
        );
        segment_to_bcd u_ones (
            .i_seg   (r_s_disp[g][6:0]),
            .o_digit (w_ones_digit[g]),
            .o_legal (w_ones_legal[g]),
            .o_blank (w_ones_blank[g])
        );
    end

    // Sample stage: capture every input once before any checking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s_lamp  <= '0;
            r_s_disp  <= '0;
            r_s_clear <= 1'b0;
        end else begin
            r_s_lamp[DIR_ROW] <= bus.row_traffic_lights;
            r_s_lamp[DIR_COL] <= bus.column_traffic_lights;
            r_s_disp[DIR_ROW] <= bus.row_display;
            r_s_disp[DIR_COL] <= bus.column_display;
            r_s_clear         <= bus.clear;
        end
    end

    // Warm-up counter: the first two samples after reset are the reset
    // values and the first captured input, so lamp checks wait for it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd2) begin
            r_warm <= r_warm + 2'd1;
        end else begin
            r_warm <= r_warm;
        end
    end

    // Lamp FSM state register, one per direction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state[DIR_ROW] <= ST_UNKNOWN;
            r_state[DIR_COL] <= ST_UNKNOWN;
        end else begin
            r_state[DIR_ROW] <= w_next_state[DIR_ROW];
            r_state[DIR_COL] <= w_next_state[DIR_COL];
        end
    end

    // Lamp FSM next state: follows the sampled lamps, even across illegal moves.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            w_next_state[d] = lamp_to_state(r_s_lamp[d]);
        end
    end

    // Lamp FSM outputs: one-hot check, state change, illegal move.
    always_comb begin
        w_onehot   = '0;
        w_changed  = '0;
        w_bad_move = '0;
        for (int d = 0; d < 2; d++) begin
            w_onehot[d]   = lamp_onehot(r_s_lamp[d]);
            w_changed[d]  = (w_next_state[d] != r_state[d]);
            w_bad_move[d] = w_onehot[d] && !legal_move(r_state[d], w_next_state[d]);
        end
    end

    // Display decode: blank, tens-blank single digit, or two legal digits.
    always_comb begin
        w_two_digit = '0;
        w_cur_count = '0;
        w_cur_valid = '0;
        w_seg_bad   = '0;
        for (int d = 0; d < 2; d++) begin
            // tens*10 + ones as (tens<<3)+(tens<<1)+ones; max 99 fits in 7 bits
            w_two_digit[d] = ({3'b000, w_tens_digit[d]} << 3) + ({3'b000, w_tens_digit[d]} << 1)
                           + {3'b000, w_ones_digit[d]};
            if (w_tens_blank[d] && w_ones_blank[d]) begin
                w_cur_valid[d] = 1'b0;
            end else if (w_tens_blank[d] && w_ones_legal[d]) begin
                w_cur_count[d] = {3'b000, w_ones_digit[d]};
                w_cur_valid[d] = 1'b1;
            end else if (w_tens_legal[d] && w_ones_legal[d] && (w_two_digit[d] <= MAX_COUNT)) begin
                w_cur_count[d] = w_two_digit[d];
                w_cur_valid[d] = 1'b1;
            end else begin
                w_seg_bad[d] = 1'b1;
            end
        end
    end

    // Countdown step check against the previous decoded value.
    always_comb begin
        w_bad_step = '0;
        for (int d = 0; d < 2; d++) begin
            if (r_valid[d] && w_cur_valid[d]) begin
                w_bad_step[d] = !((w_cur_count[d] == r_count[d]) ||
                                  (w_cur_count[d] == r_count[d] - 7'd1) ||
                                  (r_count[d] == 7'd0) ||
                                  w_changed[d]);
            end else begin
                w_bad_step[d] = 1'b0;
            end
        end
    end

    // Fault priority: lamp shape, conflict, segments, step, sequence.
    always_comb begin
        w_lamp_chk = (r_warm == 2'd2);
        if (w_lamp_chk && !(&w_onehot)) begin
            w_code = FC_LAMP;
        end else if (w_lamp_chk && !r_s_lamp[DIR_ROW][LAMP_RED] && !r_s_lamp[DIR_COL][LAMP_RED]) begin
            w_code = FC_CONFLICT;
        end else if (|w_seg_bad) begin
            w_code = FC_SEGMENT;
        end else if (|w_bad_step) begin
            w_code = FC_STEP;
        end else if (w_lamp_chk && (|w_bad_move)) begin
            w_code = FC_SEQUENCE;
        end else begin
            w_code = FC_NONE;
        end
    end

    // Fault latch: first fault sticks; clear releases it unless a new fault
    // arrives in the same cycle.
    always_comb begin
        if ((w_code != FC_NONE) && (!r_fault || r_s_clear)) begin
            w_fault_next = 1'b1;
            w_code_next  = w_code;
        end else if (r_s_clear) begin
            w_fault_next = 1'b0;
            w_code_next  = 3'd0;
        end else begin
            w_fault_next = r_fault;
            w_code_next  = r_fault_code;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_valid      <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 3'd0;
        end else begin
            r_count      <= w_cur_count;
            r_valid      <= w_cur_valid;
            r_fault      <= w_fault_next;
            r_fault_code <= w_code_next;
        end
    end

    assign bus.row_count          = r_count[DIR_ROW];
    assign bus.column_count       = r_count[DIR_COL];
    assign bus.row_count_valid    = r_valid[DIR_ROW];
    assign bus.column_count_valid = r_valid[DIR_COL];
    assign bus.fault              = r_fault;
    assign bus.fault_code         = r_fault_code;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_conflict_monitor
// Directed vectors with hand-computed expectations. The driver applies one
// vector per cycle and queues what the outputs must show two edges later; a
// separate monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_traffic_conflict_monitor;

    typedef struct {
        int         due;
        int         id;
        logic [6:0] rc;
        logic       rv;
        logic [6:0] cc;
        logic       cv;
        logic       f;
        logic [2:0] code;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   vec_id;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [13:0] bad_disp;

    traffic_conflict_monitor_if bus_if ();

    traffic_conflict_monitor dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [6:0] seg7(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F;
            1: p = 7'h06;
            2: p = 7'h5B;
            3: p = 7'h4F;
            4: p = 7'h66;
            5: p = 7'h6D;
            6: p = 7'h7D;
            7: p = 7'h07;
            8: p = 7'h7F;
            9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // n < 0 means blank; single digits use leading-zero suppression.
    function automatic logic [13:0] disp(input int n);
        logic [13:0] v;
        if (n < 0) v = 14'h0000;
        else if (n < 10) v = {7'h00, seg7(n)};
        else v = {seg7(n / 10), seg7(n % 10)};
        return v;
    endfunction

    task automatic drive(input logic [2:0] rl, input logic [2:0] cl,
                         input logic [13:0] rd, input logic [13:0] cd, input logic clr);
        bus_if.row_traffic_lights    = rl;
        bus_if.column_traffic_lights = cl;
        bus_if.row_display           = rd;
        bus_if.column_display        = cd;
        bus_if.clear                 = clr;
    endtask

    task automatic apply(input logic [2:0] rl, input logic [2:0] cl,
                         input logic [13:0] rd, input logic [13:0] cd, input logic clr,
                         input int erc, input logic erv, input int ecc, input logic ecv,
                         input logic ef, input int ecode);
        exp_t e;
        @(negedge clock);
        drive(rl, cl, rd, cd, clr);
        e.due  = cyc + 2;
        e.id   = vec_id;
        e.rc   = erc[6:0];
        e.rv   = erv;
        e.cc   = ecc[6:0];
        e.cv   = ecv;
        e.f    = ef;
        e.code = ecode[2:0];
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Numeric displays; a negative count means blank and expects valid=0.
    task automatic apply_num(input logic [2:0] rl, input logic [2:0] cl,
                             input int rn, input int cn, input logic clr,
                             input logic ef, input int ecode);
        apply(rl, cl, disp(rn), disp(cn), clr,
              (rn < 0) ? 0 : rn, (rn >= 0), (cn < 0) ? 0 : cn, (cn >= 0), ef, ecode);
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (bus_if.row_count !== 7'd0 || bus_if.row_count_valid !== 1'b0 ||
            bus_if.column_count !== 7'd0 || bus_if.column_count_valid !== 1'b0 ||
            bus_if.fault !== 1'b0 || bus_if.fault_code !== 3'd0) begin
            n_fail++;
            $display("FAIL %s: got rc=%0d rv=%0d cc=%0d cv=%0d f=%0d code=%0d, want all 0",
                     name, bus_if.row_count, bus_if.row_count_valid, bus_if.column_count,
                     bus_if.column_count_valid, bus_if.fault, bus_if.fault_code);
        end
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clock);
            #1;
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d expected outputs never seen, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compares the queued expectation on the cycle it falls due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (e.due != cyc ||
                    bus_if.row_count !== e.rc || bus_if.row_count_valid !== e.rv ||
                    bus_if.column_count !== e.cc || bus_if.column_count_valid !== e.cv ||
                    bus_if.fault !== e.f || bus_if.fault_code !== e.code) begin
                    n_fail++;
                    $display("FAIL vec%0d (cycle %0d due %0d): got rc=%0d rv=%0d cc=%0d cv=%0d f=%0d code=%0d, want rc=%0d rv=%0d cc=%0d cv=%0d f=%0d code=%0d",
                             e.id, cyc, e.due, bus_if.row_count, bus_if.row_count_valid,
                             bus_if.column_count, bus_if.column_count_valid, bus_if.fault,
                             bus_if.fault_code, e.rc, e.rv, e.cc, e.cv, e.f, e.code);
                end
            end
        end
    end

    initial begin
        cyc      = 0;
        vec_id   = 0;
        n_checks = 0;
        n_fail   = 0;
        bad_disp = {7'h00, 7'h01};
        reset    = 1'b0;
        drive(3'b001, 3'b100, disp(30), disp(-1), 1'b0);
        repeat (3) @(negedge clock);
        check_zero("reset_state");
        reset = 1'b1;

        // Legal cycle: row green 30..0, yellow 3..0, then red with column green.
        for (int n = 30; n >= 0; n--) apply_num(3'b001, 3'b100, n, -1, 1'b0, 1'b0, 0);
        for (int n = 3; n >= 0; n--)  apply_num(3'b010, 3'b100, n, -1, 1'b0, 1'b0, 0);
        apply_num(3'b100, 3'b001, 20, -1, 1'b0, 1'b0, 0);
        apply_num(3'b100, 3'b001, 19, -1, 1'b0, 1'b0, 0);

        // Conflict, later fault keeps code 2, clear, recovery.
        apply_num(3'b001, 3'b010, 18, -1, 1'b0, 1'b1, 2);
        apply_num(3'b011, 3'b010, 18, -1, 1'b0, 1'b1, 2);
        apply_num(3'b100, 3'b010, 18, -1, 1'b1, 1'b0, 0);
        apply_num(3'b100, 3'b100, 17, -1, 1'b0, 1'b0, 0);
        apply_num(3'b100, 3'b001, 17, -1, 1'b0, 1'b0, 0);

        // Bad segment pattern with tens blank.
        apply(3'b100, 3'b001, bad_disp, disp(-1), 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 3);
        apply_num(3'b100, 3'b001, 17, -1, 1'b1, 1'b0, 0);

        // Countdown: legal step, skip, skip during clear, reload from 0.
        apply_num(3'b100, 3'b001, 16, -1, 1'b0, 1'b0, 0);
        apply_num(3'b100, 3'b001, 14, -1, 1'b0, 1'b1, 4);
        apply_num(3'b100, 3'b001, 0,  -1, 1'b1, 1'b1, 4);
        apply_num(3'b100, 3'b001, 25, -1, 1'b1, 1'b0, 0);
        apply_num(3'b100, 3'b001, 24, -1, 1'b0, 1'b0, 0);

        // Illegal sequence GREEN->RED, then code 1 beats code 3 under clear.
        apply_num(3'b100, 3'b010, 23, -1, 1'b0, 1'b0, 0);
        apply_num(3'b100, 3'b100, 22, -1, 1'b0, 1'b0, 0);
        apply_num(3'b001, 3'b100, 21, -1, 1'b0, 1'b0, 0);
        apply_num(3'b100, 3'b100, 20, -1, 1'b0, 1'b1, 5);
        apply(3'b011, 3'b001, bad_disp, disp(-1), 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1);
        apply_num(3'b100, 3'b001, 19, -1, 1'b1, 1'b0, 0);

        // Raise a fault, then reset in the middle of it.
        apply_num(3'b010, 3'b001, 19, -1, 1'b0, 1'b1, 2);
        apply_num(3'b010, 3'b001, 19, -1, 1'b0, 1'b1, 2);
        drain("pre_reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_fault");
        drive(3'b001, 3'b100, disp(9), disp(99), 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Legal sequence after reset, two-digit column countdown from 99.
        apply_num(3'b001, 3'b100, 9, 99, 1'b0, 1'b0, 0);
        apply_num(3'b001, 3'b100, 8, 98, 1'b0, 1'b0, 0);
        apply_num(3'b001, 3'b100, 7, 97, 1'b0, 1'b0, 0);
        apply_num(3'b010, 3'b100, 3, 96, 1'b0, 1'b0, 0);
        drain("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
